// File: rtl/sample_framer_pkg.sv
// sample_framer_pkg: shared types and constants for the sample framer.
// Holds the framer state enum, default header byte and byte-split sizes.
package sample_framer_pkg;

    localparam int BYTE_SIZE = 8;
    localparam int WORD_SIZE = 2 * BYTE_SIZE;

    localparam logic [BYTE_SIZE-1:0] HEADER_DEF = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        HDR,
        SEND_H,
        SEND_L,
        CSUM
    } state_t;

endpackage

// File: rtl/sample_framer_ram.sv
// sample_buffer_ram: simple dual-port DEPTH x DATA_SIZE sample store.
// Ports: write (i_we, i_waddr, i_wdata), registered read (i_raddr -> o_rdata).
module sample_buffer_ram #(
    parameter  int DATA_SIZE = 14,
    parameter  int DEPTH     = 256,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                 i_clock,
    input  logic                 i_we,
    input  logic [AW-1:0]        i_waddr,
    input  logic [DATA_SIZE-1:0] i_wdata,
    input  logic [AW-1:0]        i_raddr,
    output logic [DATA_SIZE-1:0] o_rdata
);

    logic [DATA_SIZE-1:0] mem [DEPTH];

    always_ff @(posedge i_clock) begin
        if (i_we)
            mem[i_waddr] <= i_wdata;
        o_rdata <= mem[i_raddr];
    end

endmodule

// File: rtl/sample_framer.sv
// sample_framer: captures a decimated burst of samples, then streams it as
// HEADER, {hi,lo} per sample, XOR checksum over a valid/ready byte port.
// Ports: i_clock, i_reset (async low), i_data/i_data_valid/i_sample/i_gate/
// i_decim capture side; o_tdata/o_tvalid/i_tready stream side; o_idle.
module sample_framer
    import sample_framer_pkg::*;
#(
    parameter int                   DATA_SIZE = 14,
    parameter int                   DEPTH     = 256,
    parameter logic [BYTE_SIZE-1:0] HEADER    = HEADER_DEF
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic [DATA_SIZE-1:0] i_data,
    input  logic                 i_data_valid,
    input  logic                 i_sample,
    input  logic                 i_gate,
    input  logic [7:0]           i_decim,
    output logic [7:0]           o_tdata,
    output logic                 o_tvalid,
    input  logic                 i_tready,
    output logic                 o_idle
);

    localparam int AW = $clog2(DEPTH);

    state_t               state, state_d;
    logic [7:0]           decim;
    logic [7:0]           dcnt;
    logic                 first;
    logic [AW-1:0]        wr_addr;
    logic [AW-1:0]        rd_addr, rd_addr_d;
    logic [BYTE_SIZE-1:0] csum;
    logic [DATA_SIZE-1:0] rd_data;
    logic [WORD_SIZE-1:0] word;

    logic accept, wr_en, last_wr, xfer, last_rd, start;

    assign start   = (state == IDLE) && i_sample;
    assign accept  = (state == CAPTURE) && i_data_valid && i_gate;
    assign wr_en   = accept && (first || dcnt == decim - 8'd1);
    assign last_wr = wr_en && (wr_addr == AW'(DEPTH - 1));
    assign xfer    = o_tvalid && i_tready;
    assign last_rd = rd_addr == AW'(DEPTH - 1);
    assign word    = WORD_SIZE'(rd_data);
    assign o_idle  = state == IDLE;

    // The RAM is addressed with the next read address so its registered
    // output always holds the sample for the current rd_addr.
    sample_buffer_ram #(
        .DATA_SIZE (DATA_SIZE),
        .DEPTH     (DEPTH)
    ) u_ram (
        .i_clock (i_clock),
        .i_we    (wr_en),
        .i_waddr (wr_addr),
        .i_wdata (i_data),
        .i_raddr (rd_addr_d),
        .o_rdata (rd_data)
    );

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d   = state;
        rd_addr_d = rd_addr;
        o_tvalid  = 1'b0;
        o_tdata   = '0;
        unique case (state)
            IDLE: begin
                if (i_sample)
                    state_d = CAPTURE;
            end
            CAPTURE: begin
                if (last_wr)
                    state_d = HDR;
            end
            HDR: begin
                o_tvalid = 1'b1;
                o_tdata  = HEADER;
                if (i_tready) begin
                    state_d   = SEND_H;
                    rd_addr_d = '0;
                end
            end
            SEND_H: begin
                o_tvalid = 1'b1;
                o_tdata  = word[WORD_SIZE-1:BYTE_SIZE];
                if (i_tready)
                    state_d = SEND_L;
            end
            SEND_L: begin
                o_tvalid = 1'b1;
                o_tdata  = word[BYTE_SIZE-1:0];
                if (i_tready) begin
                    rd_addr_d = rd_addr + AW'(1);
                    state_d   = last_rd ? CSUM : SEND_H;
                end
            end
            CSUM: begin
                o_tvalid = 1'b1;
                o_tdata  = csum;
                if (i_tready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            decim   <= 8'd1;
            dcnt    <= '0;
            first   <= 1'b0;
            wr_addr <= '0;
            rd_addr <= '0;
            csum    <= '0;
        end else begin
            rd_addr <= rd_addr_d;
            if (start) begin
                decim   <= (i_decim == 8'd0) ? 8'd1 : i_decim;
                dcnt    <= '0;
                first   <= 1'b1;
                wr_addr <= '0;
                csum    <= '0;
            end
            if (accept) begin
                if (wr_en) begin
                    dcnt    <= '0;
                    first   <= 1'b0;
                    wr_addr <= wr_addr + AW'(1);
                end else begin
                    dcnt <= dcnt + 8'd1;
                end
            end
            if (xfer && (state == SEND_H || state == SEND_L))
                csum <= csum ^ o_tdata;
        end
    end

endmodule

// File: tb/tb_sample_framer.sv
// tb_sample_framer: directed bench for sample_framer with DEPTH=4.
// Drives and samples on the falling clock edge; checks every frame byte.
module tb_sample_framer;

    logic        clk = 1'b0;
    logic        i_reset;
    logic [13:0] i_data;
    logic        i_data_valid;
    logic        i_sample;
    logic        i_gate;
    logic [7:0]  i_decim;
    logic [7:0]  o_tdata;
    logic        o_tvalid;
    logic        i_tready;
    logic        o_idle;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [10];

    always #5 clk = ~clk;

    sample_framer #(
        .DATA_SIZE (14),
        .DEPTH     (4),
        .HEADER    (8'hA5)
    ) dut (
        .i_clock      (clk),
        .i_reset      (i_reset),
        .i_data       (i_data),
        .i_data_valid (i_data_valid),
        .i_sample     (i_sample),
        .i_gate       (i_gate),
        .i_decim      (i_decim),
        .o_tdata      (o_tdata),
        .o_tvalid     (o_tvalid),
        .i_tready     (i_tready),
        .o_idle       (o_idle)
    );

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [7:0] d);
        @(negedge clk);
        chk("idle_before", 16'(o_idle), 16'd1);
        i_decim  = d;
        i_sample = 1'b1;
        @(negedge clk);
        i_sample = 1'b0;
        i_decim  = 8'd7;
        chk("idle_fall", 16'(o_idle), 16'd0);
    endtask

    task automatic feed(input int n, input int v, input logic g);
        for (int k = 0; k < n; k++) begin
            i_data       = 14'(v + k);
            i_data_valid = 1'b1;
            i_gate       = g;
            chk("busy", 16'(o_tvalid), 16'd0);
            @(negedge clk);
        end
        i_data_valid = 1'b0;
        i_gate       = 1'b1;
    endtask

    task automatic hdr_check();
        chk("hdr_valid", 16'(o_tvalid), 16'd1);
        chk("hdr_data", 16'(o_tdata), 16'hA5);
    endtask

    task automatic collect(input logic rnd, input logic pulse);
        int         idx = 0;
        int         n = 0;
        logic       stall = 1'b0;
        logic [7:0] held = '0;
        while (idx < 10 && n < 300) begin
            if (stall) begin
                chk("stall_valid", 16'(o_tvalid), 16'd1);
                chk("stall_data", 16'(o_tdata), 16'(held));
            end else if (!rnd) begin
                chk("no_gap", 16'(o_tvalid), 16'd1);
            end
            i_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            i_sample = pulse && (idx == 3);
            if (o_tvalid && i_tready) begin
                chk($sformatf("byte%0d", idx), 16'(o_tdata),
                    16'(exp_q[idx]));
                idx++;
            end
            stall = o_tvalid && !i_tready;
            held  = o_tdata;
            n++;
            @(negedge clk);
        end
        i_sample = 1'b0;
        chk("frame_len", 16'(idx), 16'd10);
        chk("end_valid", 16'(o_tvalid), 16'd0);
        chk("end_idle", 16'(o_idle), 16'd1);
    endtask

    initial begin
        i_reset      = 1'b0;
        i_data       = '0;
        i_data_valid = 1'b0;
        i_sample     = 1'b0;
        i_gate       = 1'b1;
        i_decim      = 8'd1;
        i_tready     = 1'b0;
        #3;
        chk("rst_idle", 16'(o_idle), 16'd1);
        chk("rst_valid", 16'(o_tvalid), 16'd0);
        chk("rst_data", 16'(o_tdata), 16'd0);
        @(negedge clk);
        i_reset = 1'b1;

        // ramp, decim 1
        start(8'd1);
        feed(4, 1, 1'b1);
        hdr_check();
        exp_q = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h02,
                  8'h00, 8'h03, 8'h00, 8'h04, 8'h04};
        collect(1'b0, 1'b0);

        // decim 3 keeps 0,3,6,9
        start(8'd3);
        feed(10, 0, 1'b1);
        hdr_check();
        exp_q = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h03,
                  8'h00, 8'h06, 8'h00, 8'h09, 8'h0C};
        collect(1'b0, 1'b0);

        // decim 2 with a 5-cycle gate pause mid-capture
        start(8'd2);
        feed(2, 'h20, 1'b1);
        feed(5, 'h100, 1'b0);
        feed(5, 'h22, 1'b1);
        hdr_check();
        exp_q = '{8'hA5, 8'h00, 8'h20, 8'h00, 8'h22,
                  8'h00, 8'h24, 8'h00, 8'h26, 8'h00};
        collect(1'b0, 1'b0);

        // random ready, extra request during send
        start(8'd1);
        feed(4, 'h3A1, 1'b1);
        hdr_check();
        exp_q = '{8'hA5, 8'h03, 8'hA1, 8'h03, 8'hA2,
                  8'h03, 8'hA3, 8'h03, 8'hA4, 8'h04};
        collect(1'b1, 1'b1);
        i_tready = 1'b0;
        repeat (3) @(negedge clk);
        chk("no_requeue", 16'(o_idle), 16'd1);

        // reset during SEND_L
        start(8'd1);
        feed(4, 'h155, 1'b1);
        hdr_check();
        i_tready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("in_send_l", 16'(o_tdata), 16'h55);
        #2 i_reset = 1'b0;
        #1;
        chk("arst_idle", 16'(o_idle), 16'd1);
        chk("arst_valid", 16'(o_tvalid), 16'd0);
        chk("arst_data", 16'(o_tdata), 16'd0);
        i_tready = 1'b0;
        #1 i_reset = 1'b1;
        start(8'd1);
        feed(4, 'h201, 1'b1);
        hdr_check();
        exp_q = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h02,
                  8'h02, 8'h03, 8'h02, 8'h04, 8'h04};
        collect(1'b0, 1'b0);

        // decim 0 acts as 1; full-scale sample split
        start(8'd0);
        feed(4, 'h3FFD, 1'b1);
        hdr_check();
        exp_q = '{8'hA5, 8'h3F, 8'hFD, 8'h3F, 8'hFE,
                  8'h3F, 8'hFF, 8'h00, 8'h00, 8'hC3};
        collect(1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sample_framer.md
# sample_framer

Capture-and-frame stage between the ADC data conversor and the UART transmitter of the acquisition path. On a sample request it records a burst of decimated 14-bit samples into an internal buffer. It then streams the burst as a framed byte sequence: header, sample bytes and XOR checksum. Output uses an AXI-stream style handshake that connects directly to a `uart_tx` instance.

## Interface
- `DATA_SIZE`, 14, sample width in bits (≤16)
- `DEPTH`, 256, samples per burst; power of two, ≥2
- `HEADER`, 8'hA5, frame start byte
- `i_clock` in 1 — system clock
- `i_reset` in 1 — asynchronous, active-low reset
- `i_data` in DATA_SIZE — conversor sample
- `i_data_valid` in 1 — `i_data` valid this cycle
- `i_sample` in 1 — single-cycle capture request
- `i_gate` in 1 — level; capture writes only while high
- `i_decim` in 8 — decimation factor, latched at start; 0 is treated as 1
- `o_tdata` out 8 — byte to UART
- `o_tvalid` out 1 — byte valid
- `i_tready` in 1 — UART accepts byte
- `o_idle` out 1 — high only in IDLE

## Operation
- FSM states: IDLE, CAPTURE, HDR, SEND_H, SEND_L, CSUM.
- **IDLE**
  - `o_idle`=1.
  - `i_sample`=1 → CAPTURE. Latch `decim` = max(`i_decim`, 1). Clear the write address, decimation counter and checksum.
- **CAPTURE**
  - A sample is accepted in a cycle where `i_data_valid`=1 and `i_gate`=1.
  - On an accepted sample, the decimation counter increments.
  - When the counter reaches `decim`-1, or on the first accepted sample after start, write `i_data` at the write address, increment the address and reset the counter.
  - While `i_gate`=0 the FSM pauses: no writes, counter holds.
  - After the DEPTH-th write → HDR.
- **HDR**
  - `o_tdata`=HEADER.
  - On handshake → SEND_H, read address = 0.
- **SEND_H**
  - `o_tdata` = sample[15:8] of the sample zero-extended to 16 bits.
  - On handshake → SEND_L.
- **SEND_L**
  - `o_tdata` = sample[7:0].
  - On handshake: read address increments. If this was the last sample → CSUM, else → SEND_H.
- **CSUM**
  - `o_tdata` = XOR of every sample byte sent (HEADER excluded).
  - On handshake → IDLE.
- A frame is always 2·DEPTH+2 bytes.
- `i_sample` outside IDLE is ignored; there is no queuing.
- Changes to `i_decim` after start have no effect until the next capture.
- Handshake: a byte transfers on `o_tvalid`&&`i_tready`. Once raised, `o_tvalid` stays high and `o_tdata` stays stable until the transfer completes.

## Timing
- **Reset values:** state IDLE, `o_idle`=1, `o_tvalid`=0, `o_tdata`=0, all counters/addresses/checksum 0.
- **Reset mid-operation:** the frame is aborted immediately and the FSM returns to IDLE. Buffer contents are don't-care.
- **`i_sample` to capture:** `i_sample` registered at edge N → CAPTURE at N+1. `o_idle` falls at N+1.
- **Capture duration:** (DEPTH−1)·decim+1 qualified cycles after entry.
- **Last write to header:** `o_tvalid` rises with HEADER on the cycle after the last write.
- **Buffer read latency:** the buffer read is 1-cycle synchronous. The read address is presented one cycle ahead so that `o_tvalid` never drops between consecutive bytes while `i_tready` is held high. Back-to-back transfers sustain 1 byte/cycle.
- **End of frame:** after the CSUM handshake, `o_tvalid`=0 and `o_idle`=1 on the next cycle. A new `i_sample` is accepted in that same cycle.
- **Simultaneous gate-fall and last qualifying sample:** the write occurs, because gate is sampled in the same cycle as the data.

## Structure
- The shared package holds:
  - the state enum;
  - `HEADER` default;
  - byte-split helper constants (`BYTE_SIZE`=8).
- One sub-module, `sample_buffer_ram`: simple dual-port, DEPTH×DATA_SIZE, one write port, registered read port, inferable as BRAM/LUTRAM.
- Counters are width $clog2(DEPTH) for addresses and 8 bits for decimation.

## Test plan
1. DEPTH=4, decim=1, ramp 0x0001..0x0004, `i_tready`=1. Bytes must be A5,00,01,00,02,00,03,00,04,04 with no `o_tvalid` gaps.
2. `i_decim`=3, continuous valid data 0..20. Stored samples must be 0,3,6,9. Checksum = 0^3^6^9 = 0x0C.
3. `i_gate` low for 5 cycles mid-capture. No samples are skipped or inserted, and capture length stretches by exactly 5 cycles.
4. `i_tready` toggled randomly, with `i_sample` pulsed during the send. `o_tdata` must stay stable while stalled, the second request is ignored, and exactly 10 bytes are sent.
5. Assert reset (`i_reset`=0) during SEND_L. All outputs return to their reset values asynchronously, and a subsequent `i_sample` yields a complete, correct frame.
6. `i_decim`=0 with sample 0x3FFF. High byte is 0x3F, low byte is 0xFF, and behaviour is the same as decim=1.
